// File: rtl/reg_scoreboard.sv
// In-order register scoreboard: tracks in-flight destination registers between ID and WB, flags RAW stalls.
// Latency: stall is combinational (zero cycles); count/full/empty/error update on the rising edge.
// Backpressure: stall holds ID on a source match or when full with no same-cycle retire; overflow is dropped and flagged.
module reg_scoreboard #(
    parameter int DEPTH = 4,
    parameter int RA_W  = 5,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [RA_W-1:0] i_rs1,
    input  logic [RA_W-1:0] i_rs2,
    input  logic            i_issue_valid,
    input  logic [RA_W-1:0] i_issue_rd,
    input  logic            i_wb_valid,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_flush_valid,
    input  logic [CW-1:0]   i_flush_cnt,
    output logic            o_stall,
    output logic            o_full,
    output logic            o_empty,
    output logic [CW-1:0]   o_count,
    output logic            o_error
);

    logic [RA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_error;

    logic            w_full;
    logic            w_empty;
    logic            w_pop_req;
    logic            w_pop;
    logic            w_pop_err;
    logic [CW-1:0]   w_cnt_pop;
    logic [PW-1:0]   w_head_nx;
    logic            w_push_req;
    logic            w_push;
    logic            w_push_drop;
    logic            w_flush_over;
    logic            w_hit1;
    logic            w_hit2;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // x0 is never tracked, so writebacks to x0 never retire anything.
    assign w_pop_req = i_wb_valid && (i_wb_rd != '0);
    assign w_pop     = w_pop_req && !w_empty;
    assign w_pop_err = w_pop_req && (w_empty || (r_mem[r_head] != i_wb_rd));

    // Occupancy and head after the retire, which the flush and push then build on.
    assign w_cnt_pop = r_count - CW'(w_pop);
    assign w_head_nx = r_head + PW'(w_pop);

    assign w_flush_over = i_flush_valid && (i_flush_cnt > w_cnt_pop);

    // A flush squashes the issuing instruction, so push only happens without one.
    assign w_push_req  = i_issue_valid && (i_issue_rd != '0) && !i_flush_valid;
    assign w_push      = w_push_req && (w_cnt_pop != CW'(DEPTH));
    assign w_push_drop = w_push_req && (w_cnt_pop == CW'(DEPTH));

    // Source match against live entries; the head retiring this cycle is skipped since the regfile writes through.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && !((i == 0) && w_pop)) begin
                if ((i_rs1 != '0) && (r_mem[r_head + PW'(i)] == i_rs1)) w_hit1 = 1'b1;
                if ((i_rs2 != '0) && (r_mem[r_head + PW'(i)] == i_rs2)) w_hit2 = 1'b1;
            end
        end
    end

    assign o_stall = w_hit1 || w_hit2 || (w_full && !w_pop);
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_error = r_error;

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push) begin
            r_mem[r_tail] <= i_issue_rd;
        end
    end

    // Pointer, count and sticky error update in pop -> flush -> push order.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_head <= w_head_nx;
            if (w_pop_err || w_push_drop || w_flush_over) begin
                r_error <= 1'b1;
            end
            if (i_flush_valid) begin
                if (w_flush_over) begin
                    r_tail  <= w_head_nx;
                    r_count <= '0;
                end else begin
                    r_tail  <= r_tail - i_flush_cnt[PW-1:0];
                    r_count <= w_cnt_pop - i_flush_cnt;
                end
            end else if (w_push) begin
                r_tail  <= r_tail + PW'(1);
                r_count <= w_cnt_pop + CW'(1);
            end else begin
                r_count <= w_cnt_pop;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stimulus queues expected outputs, monitor compares on the falling edge.
// Latency: expectations describe the cycle the inputs are applied (registered state from before that edge).
// Backpressure: none; every stimulus step is checked exactly once.
module tb_reg_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] rs1, rs2, issue_rd, wb_rd;
    logic       issue_valid, wb_valid, flush_valid;
    logic [2:0] flush_cnt;
    logic       stall, full, empty, error;
    logic [2:0] count;

    typedef struct {
        string      name;
        logic       stall;
        logic       full;
        logic       empty;
        logic [2:0] count;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req;
    int   total;
    int   bad;

    reg_scoreboard #(.DEPTH(4), .RA_W(5)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_flush_valid (flush_valid),
        .i_flush_cnt   (flush_cnt),
        .o_stall       (stall),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever a step is presented, pop its expectation and compare every output.
    always @(negedge clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL no_expectation: monitor saw a step with an empty queue");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (stall !== e.stall) begin
                    bad++;
                    $display("FAIL %s.stall: got %b want %b", e.name, stall, e.stall);
                end
                total++;
                if (count !== e.count) begin
                    bad++;
                    $display("FAIL %s.count: got %0d want %0d", e.name, count, e.count);
                end
                total++;
                if (full !== e.full || empty !== e.empty) begin
                    bad++;
                    $display("FAIL %s.full_empty: got %b%b want %b%b", e.name, full, empty, e.full, e.empty);
                end
                total++;
                if (error !== e.err) begin
                    bad++;
                    $display("FAIL %s.error: got %b want %b", e.name, error, e.err);
                end
            end
        end
    end

    // One clocked step: apply inputs, queue the expected response for this cycle, advance past the edge.
    task automatic step(input string nm, input logic rst_n,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic iv, input logic [4:0] ird,
                        input logic wv, input logic [4:0] wrd,
                        input logic fv, input logic [2:0] fc,
                        input logic e_stall, input logic [2:0] e_count, input logic e_err);
        exp_t e;
        reset = rst_n; rs1 = s1; rs2 = s2;
        issue_valid = iv; issue_rd = ird;
        wb_valid = wv; wb_rd = wrd;
        flush_valid = fv; flush_cnt = fc;
        e.name  = nm;
        e.stall = e_stall;
        e.count = e_count;
        e.full  = (e_count == 3'd4);
        e.empty = (e_count == 3'd0);
        e.err   = e_err;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic do_reset();
        step("rst", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, dut.o_count, dut.o_error);
    endtask

    initial begin
        total = 0; bad = 0; chk_req = 1'b0;
        reset = 1'b0; rs1 = 0; rs2 = 0; issue_valid = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; flush_valid = 0; flush_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        //          name        rst  rs1 rs2 iv ird wv wrd fv fc  stall cnt err
        step("reset_state",     1,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        // Three issues then RAW queries.
        step("iss5",            1,   0,  0,  1, 5,  0, 0,  0, 0,  0,    0,  0);
        step("iss6",            1,   0,  0,  1, 6,  0, 0,  0, 0,  0,    1,  0);
        step("iss7",            1,   0,  0,  1, 7,  0, 0,  0, 0,  0,    2,  0);
        step("rs1_6",           1,   6,  0,  0, 0,  0, 0,  0, 0,  1,    3,  0);
        step("rs_0_9",          1,   0,  9,  0, 0,  0, 0,  0, 0,  0,    3,  0);
        step("rs2_7",           1,   0,  7,  0, 0,  0, 0,  0, 0,  1,    3,  0);
        // Writeback of the head hides it from matching in the same cycle.
        step("wb5_rs5",         1,   5,  0,  0, 0,  1, 5,  0, 0,  0,    3,  0);
        step("rs5_gone",        1,   5,  0,  0, 0,  0, 0,  0, 0,  0,    2,  0);
        step("rs6_head",        1,   6,  0,  0, 0,  0, 0,  0, 0,  1,    2,  0);
        step("wb6_rs6",         1,   6,  0,  0, 0,  1, 6,  0, 0,  0,    2,  0);
        step("wb7",             1,   0,  0,  0, 0,  1, 7,  0, 0,  0,    1,  0);
        step("drained1",        1,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        // Fill to DEPTH, then retire+issue while full.
        step("iss1",            1,   0,  0,  1, 1,  0, 0,  0, 0,  0,    0,  0);
        step("iss2",            1,   0,  0,  1, 2,  0, 0,  0, 0,  0,    1,  0);
        step("iss3",            1,   0,  0,  1, 3,  0, 0,  0, 0,  0,    2,  0);
        step("iss4",            1,   0,  0,  1, 4,  0, 0,  0, 0,  0,    3,  0);
        step("full_stall",      1,   9,  0,  0, 0,  0, 0,  0, 0,  1,    4,  0);
        step("full_wb_iss",     1,   9,  0,  1, 8,  1, 1,  0, 0,  0,    4,  0);
        step("full_rs2",        1,   2,  0,  0, 0,  0, 0,  0, 0,  1,    4,  0);
        step("wb2",             1,   0,  0,  0, 0,  1, 2,  0, 0,  0,    4,  0);
        step("wb3_rs1_gone",    1,   1,  0,  0, 0,  1, 3,  0, 0,  0,    3,  0);
        step("wb4_rs8",         1,   8,  0,  0, 0,  1, 4,  0, 0,  1,    2,  0);
        step("wb8",             1,   0,  0,  0, 0,  1, 8,  0, 0,  0,    1,  0);
        step("drained2",        1,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        // Duplicate destinations.
        step("dup_iss3a",       1,   0,  0,  1, 3,  0, 0,  0, 0,  0,    0,  0);
        step("dup_iss3b",       1,   0,  0,  1, 3,  0, 0,  0, 0,  0,    1,  0);
        step("dup_wb3_rs3",     1,   3,  0,  0, 0,  1, 3,  0, 0,  1,    2,  0);
        step("dup_rs3",         1,   3,  0,  0, 0,  0, 0,  0, 0,  1,    1,  0);
        step("dup_wb3_last",    1,   3,  0,  0, 0,  1, 3,  0, 0,  0,    1,  0);
        step("dup_drained",     1,   3,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        // Flush of two youngest squashes the same-cycle issue.
        step("f_iss1",          1,   0,  0,  1, 1,  0, 0,  0, 0,  0,    0,  0);
        step("f_iss2",          1,   0,  0,  1, 2,  0, 0,  0, 0,  0,    1,  0);
        step("f_iss3",          1,   0,  0,  1, 3,  0, 0,  0, 0,  0,    2,  0);
        step("flush2_iss9",     1,   0,  0,  1, 9,  0, 0,  1, 2,  0,    3,  0);
        step("f_rs1",           1,   1,  0,  0, 0,  0, 0,  0, 0,  1,    1,  0);
        step("f_rs2_gone",      1,   2,  0,  0, 0,  0, 0,  0, 0,  0,    1,  0);
        step("f_rs9_gone",      1,   9,  0,  0, 0,  0, 0,  0, 0,  0,    1,  0);
        step("f_wb1",           1,   0,  0,  0, 0,  1, 1,  0, 0,  0,    1,  0);
        step("f_drained",       1,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        // Writeback while empty.
        step("rstA",            0,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        step("e_wb4_empty",     1,   0,  0,  0, 0,  1, 4,  0, 0,  0,    0,  0);
        step("e_err_empty",     1,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        // Head mismatch still pops; reset clears error.
        step("rstB",            0,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        step("m_iss2",          1,   0,  0,  1, 2,  0, 0,  0, 0,  0,    0,  0);
        step("m_wb3",           1,   0,  0,  0, 0,  1, 3,  0, 0,  0,    1,  0);
        step("m_err_popped",    1,   2,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        step("rstC",            0,   2,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        step("m_cleared",       1,   2,  0,  0, 0,  0, 0,  0, 0,  0,    0,  0);
        // Overflow: issue while full without retire is dropped.
        step("o_iss1",          1,   0,  0,  1, 1,  0, 0,  0, 0,  0,    0,  0);
        step("o_iss2",          1,   0,  0,  1, 2,  0, 0,  0, 0,  0,    1,  0);
        step("o_iss3",          1,   0,  0,  1, 3,  0, 0,  0, 0,  0,    2,  0);
        step("o_iss4",          1,   0,  0,  1, 4,  0, 0,  0, 0,  0,    3,  0);
        step("o_iss6_full",     1,   0,  0,  1, 6,  0, 0,  0, 0,  1,    4,  0);
        step("o_err",           1,   6,  0,  0, 0,  0, 0,  0, 0,  1,    4,  1);
        // Pop plus flush of all remaining entries: legal, leaves scoreboard empty.
        step("o_wb1_flush3",    1,   0,  0,  0, 0,  1, 1,  1, 3,  0,    4,  1);
        step("o_empty",         1,   4,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        // Flush larger than occupancy.
        step("rstD",            0,   0,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        step("fo_iss1",         1,   0,  0,  1, 1,  0, 0,  0, 0,  0,    0,  0);
        step("fo_flush2",       1,   0,  0,  0, 0,  0, 0,  1, 2,  0,    1,  0);
        step("fo_err",          1,   1,  0,  0, 0,  0, 0,  0, 0,  0,    0,  1);
        step("fo_iss7_reuse",   1,   0,  0,  1, 7,  0, 0,  0, 0,  0,    0,  1);
        step("fo_rs7",          1,   7,  0,  0, 0,  0, 0,  0, 0,  1,    1,  1);

        // Bounded wait for the monitor to drain the expectation queue.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- In-order register scoreboard between ID and WB of the 5-stage pipeline.
- ID records each destination register it issues. WB retires that destination when it writes back.
- The block answers RAW-hazard queries for the instruction currently in ID, producing the ID stall.
- Replaces per-stage rd comparison with a tracked in-flight list, so stall policy no longer depends on pipeline depth.

Parameters:
- DEPTH, 4, max in-flight writing instructions tracked (power of 2, >=2).
- RA_W, `REG_ADDR_SIZE+1 (5), register address width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- rs1  input  RA_W  source 1 of instruction in ID.
- rs2  input  RA_W  source 2 of instruction in ID.
- issue_valid  input  1  instruction leaves ID into EXE this cycle and writes rd.
- issue_rd  input  RA_W  destination of issuing instruction.
- wb_valid  input  1  instruction in WB writes register file this cycle.
- wb_rd  input  RA_W  destination being written back.
- flush_valid  input  1  squash younger in-flight instructions.
- flush_cnt  input  $clog2(DEPTH)+1  number of youngest entries to discard.
- stall  output  1  ID must hold (combinational).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  entries in flight.
- error  output  1  sticky protocol-violation flag.

Behaviour:
- Storage: circular FIFO of DEPTH rd entries with head (oldest), tail and count registers. Pointers wrap modulo DEPTH.
- Reset (reset==0 at posedge):
  - head, tail, count = 0; error = 0.
  - Outputs: empty=1, full=0, count=0, stall=0.
  - Entry contents are don't-care.
  - Reset overrides all other inputs in the same cycle and aborts any in-progress flush.
- x0 handling:
  - issue with issue_rd==0 does not push.
  - wb with wb_rd==0 does not pop.
  - rs==0 never matches.
- Pop:
  - wb_valid && wb_rd!=0 pops head.
  - If empty, or head entry != wb_rd: error<=1. A mismatch still pops; popping while empty leaves the state unchanged.
- Push:
  - issue_valid && issue_rd!=0 writes issue_rd at tail and advances tail.
  - Push when full with no same-cycle pop is dropped and sets error.
  - Push and pop in the same cycle while full is accepted; count is unchanged.
- Flush:
  - Applied after pop in the same cycle; discards the youngest flush_cnt entries (tail -= flush_cnt).
  - A same-cycle push is dropped because the issuing instruction is squashed.
  - If flush_cnt > count remaining after the pop: count->0, tail=head, error<=1.
- Update order within a cycle: pop, then flush, then push (push only if no flush). count is updated to match.
- stall, combinational, zero latency:
  - Asserts when (rs1!=0 and rs1 matches any valid entry) OR (rs2!=0 and rs2 matches any valid entry) OR (full and no pop this cycle).
  - The head entry being popped this cycle is excluded from matching, because the register file is write-through.
  - stall does not depend on issue_valid. ID is responsible for not asserting issue_valid while stall=1; doing so is caught by the overflow/error rules above.
- Duplicates: multiple entries may hold the same rd. A match persists until the last one is popped.
- full, empty, count are driven from registers; no combinational path from inputs.

Test Plan:
- Reset, then issue rd=5,6,7 on 3 consecutive cycles -> count=3. With rs1=6: stall=1. With rs1=0, rs2=9: stall=0.
- Entries {5,6}; wb_rd=5 with rs1=5 in the same cycle -> stall=0 that cycle; next cycle count=1, head=6.
- Fill DEPTH=4 entries {1,2,3,4}; rs1=9 -> stall=1 (full). Add wb_rd=1 in the same cycle with issue_rd=8 -> accepted, count stays 4, entries {2,3,4,8}.
- Issue rd=3 twice, wb_rd=3 once -> rs1=3 still stalls. Second wb_rd=3 -> stall=0, empty=1.
- Entries {1,2,3}; flush_valid with flush_cnt=2 plus issue_rd=9 -> count=1, only rd=1 remains, 9 not pushed, error=0.
- Error cases, each from reset:
  - wb_rd=4 while empty -> error=1.
  - Head=2, wb_rd=3 -> error=1 and head pops.
  - Then reset=0 for one cycle -> error=0, count=0, stall=0.
